plab1_imul_varlat_mul_n: RTL and testbench

PLAB1_IMUL_VARLAT_MUL_N -- requirements
Module: plab1_imul_varlat_mul_n

---
 rtl/plab1_imul_varlat_mul_n.sv | 170 +++++++++++++++++
 tb/tb_plab1_imul_varlat_mul_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plab1_imul_varlat_mul_n.sv
// Variable-latency iterative multiplier that skips runs of trailing zeros in B.
// Define PLAB1_IMUL_VARLAT_MULH_EN to add the MULH/MULHU/MULHSU high-half funcs.
module plab1_imul_varlat_mul_n #(
  parameter int unsigned P_NBITS = 32,
  parameter int unsigned P_SKIP  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [1:0]         in_func,
  input  logic [P_NBITS-1:0] in_a,
  input  logic [P_NBITS-1:0] in_b,
  input  logic               in_domain,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [P_NBITS-1:0] out_msg,
  output logic               out_domain
);

`ifdef PLAB1_IMUL_VARLAT_MULH_EN
  localparam int unsigned AW = 2 * P_NBITS;
`else
  localparam int unsigned AW = P_NBITS;
`endif
  localparam int unsigned ZW = $clog2(P_SKIP + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
    NEG  = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               live;
  logic [AW-1:0]      acc, acc_nxt;
  logic [AW-1:0]      a_reg, a_nxt;
  logic [P_NBITS-1:0] b_reg, b_nxt;
  logic               dom_reg, dom_nxt;
  logic               accept;
  logic [P_NBITS-1:0] a_mag, b_mag;
  logic [ZW-1:0]      skip, shamt;
  logic               hit, found;
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
  logic [1:0]         func_reg, func_nxt;
  logic               neg_reg, neg_nxt;
  logic               a_neg, b_neg;
`else
  logic               unused_func;
  assign unused_func = ^in_func;
`endif

  // Trailing-zero count of B, capped at P_SKIP; hit = bit at that position is set
  always_comb begin
    skip  = ZW'(P_SKIP);
    hit   = b_reg[P_SKIP];
    found = 1'b0;
    for (int i = 0; i < int'(P_SKIP); i++) begin
      if (!found && b_reg[i]) begin
        found = 1'b1;
        skip  = ZW'(i);
        hit   = 1'b1;
      end
    end
    shamt = skip + ZW'(1);
  end

  // Operand magnitudes captured at accept; MUL low half needs no sign fix-up
  always_comb begin
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
    a_neg = (in_func == 2'd1 || in_func == 2'd3) && in_a[P_NBITS-1];
    b_neg = (in_func == 2'd1) && in_b[P_NBITS-1];
    a_mag = a_neg ? -in_a : in_a;
    b_mag = b_neg ? -in_b : in_b;
`else
    a_mag = in_a;
    b_mag = in_b;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    dom_nxt   = dom_reg;
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
    func_nxt  = func_reg;
    neg_nxt   = neg_reg;
`endif
    in_rdy    = live && (state == IDLE || (state == DONE && out_rdy));
    out_val   = (state == DONE);
    accept    = in_val && in_rdy;

    case (state)
      IDLE: ;
      CALC: begin
        if (hit) acc_nxt = acc + (a_reg << skip);
        a_nxt = a_reg << shamt;
        b_nxt = b_reg >> shamt;
        if (b_nxt == '0) begin
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
          state_nxt = neg_reg ? NEG : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
      NEG: begin
        acc_nxt   = -acc;
        state_nxt = DONE;
      end
`endif
      DONE: if (out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Accept overrides DONE->IDLE so back-to-back requests lose no cycle
    if (accept) begin
      state_nxt = CALC;
      acc_nxt   = '0;
      a_nxt     = AW'(a_mag);
      b_nxt     = b_mag;
      dom_nxt   = in_domain;
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
      func_nxt  = in_func;
      neg_nxt   = a_neg ^ b_neg;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      live     <= 1'b0;
      acc      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      dom_reg  <= 1'b0;
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
      func_reg <= 2'd0;
      neg_reg  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      live     <= 1'b1;
      acc      <= acc_nxt;
      a_reg    <= a_nxt;
      b_reg    <= b_nxt;
      dom_reg  <= dom_nxt;
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
      func_reg <= func_nxt;
      neg_reg  <= neg_nxt;
`endif
    end
  end

`ifdef PLAB1_IMUL_VARLAT_MULH_EN
  assign out_msg = (func_reg == 2'd0) ? acc[P_NBITS-1:0] : acc[AW-1:P_NBITS];
`else
  assign out_msg = acc;
`endif
  assign out_domain = dom_reg;

endmodule

// File: tb/tb_plab1_imul_varlat_mul_n.sv
// Scoreboard bench for plab1_imul_varlat_mul_n (P_NBITS=32, P_SKIP=8).
module tb_plab1_imul_varlat_mul_n;
  localparam int unsigned NB = 32;
  localparam int unsigned SK = 8;

  logic          clk;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [1:0]    in_func;
  logic [NB-1:0] in_a;
  logic [NB-1:0] in_b;
  logic          in_domain;
  logic          out_val;
  logic          out_rdy;
  logic [NB-1:0] out_msg;
  logic          out_domain;

  plab1_imul_varlat_mul_n #(.P_NBITS(NB), .P_SKIP(SK)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_func    (in_func),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_domain  (in_domain),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .out_domain (out_domain)
  );

  typedef struct {
    logic [31:0] msg;
    logic        dom;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0 random, 1 always ready, 2 hold off

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference result: plain 64-bit product of sign/zero-extended operands
  function automatic logic [31:0] ref_msg(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
    ea = (f == 2'd1 || f == 2'd3) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (f == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (f == 2'd0) ? p[31:0] : p[63:32];
`else
    ea = {32'b0, a};
    eb = {32'b0, b};
    p  = ea * eb;
    return (f == 2'd3 && a == 32'hdead_beef) ? p[31:0] : p[31:0];
`endif
  endfunction

  // Reference latency: number of capped zero-skip steps to consume B, plus negate step
  function automatic int ref_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    int z;
    logic [31:0] bb = b;
    do begin
      z = 0;
      while (z < int'(SK) && bb[z] == 1'b0) z++;
      k++;
      bb = bb >> (z + 1);
    end while (bb != 32'd0);
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
    if ((f == 2'd1 && (a[31] ^ b[31])) || (f == 2'd3 && a[31])) k++;
`else
    if (f == 2'd3 && a == 32'hdead_beef) k = k + 0;
`endif
    return k;
  endfunction

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic d, input logic [31:0] msg, input int lat, input bit now);
    int waited = 0;
    exp_t e;
    @(negedge clk);
    in_val = 1'b1; in_func = f; in_a = a; in_b = b; in_domain = d;
    #1;
    if (now) chk("b2b_accept_from_done", {62'b0, out_val, in_rdy}, 64'd3);
    while (!in_rdy && waited < 500) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_rdy) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: in_rdy stayed 0 for %0d cycles, want 1", waited);
      in_val = 1'b0;
      return;
    end
    e.msg = msg; e.dom = d; e.acc_cyc = cyc + 1; e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_val = 1'b0;
  endtask

  task automatic issue_m(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic d);
    issue(f, a, b, d, ref_msg(f, a, b), ref_lat(f, a, b), 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: drives out_rdy, compares every presented response against the queue head
  initial begin
    bit seen = 0;
    int idle = 0;
    exp_t e;
    out_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 0; idle = 0; out_rdy = 1'b0;
      end else begin
        case (rdy_mode)
          0:       out_rdy = ($urandom_range(0, 3) != 0);
          1:       out_rdy = 1'b1;
          default: out_rdy = 1'b0;
        endcase
        if (out_val) begin
          idle = 0;
          if (exp_q.size() == 0) begin
            chk("spurious_out_val", {63'b0, out_val}, 64'd0);
          end else begin
            e = exp_q[0];
            if (!seen) begin
              chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
              seen = 1;
            end
            chk("out_msg", {32'b0, out_msg}, {32'b0, e.msg});
            chk("out_domain", {63'b0, out_domain}, {63'b0, e.dom});
            if (out_rdy) begin
              void'(exp_q.pop_front());
              seen = 0;
            end
          end
        end else if (exp_q.size() != 0) begin
          idle++;
          if (idle > 300) begin
            n_vec++; n_fail++;
            $display("FAIL response_timeout: no out_val for %0d cycles, want response", idle);
            exp_q.delete();
            idle = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    int w;
    reset = 1'b0; in_val = 1'b0; in_func = 2'd0; in_a = '0; in_b = '0; in_domain = 1'b0;
    #3;
    chk("reset_out_val", {63'b0, out_val}, 64'd0);
    chk("reset_in_rdy", {63'b0, in_rdy}, 64'd0);
    chk("reset_out_msg", {32'b0, out_msg}, 64'd0);
    chk("reset_out_domain", {63'b0, out_domain}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_release", {63'b0, in_rdy}, 64'd1);

    rdy_mode = 1;
    issue(2'd0, 32'd3, 32'd5, 1'b1, 32'd15, 2, 1'b0);
    issue(2'd0, 32'd7, 32'h8000_0000, 1'b0, 32'h8000_0000, 4, 1'b0);
    issue(2'd0, 32'd7, 32'd0, 1'b1, 32'd0, 1, 1'b0);
`ifdef PLAB1_IMUL_VARLAT_MULH_EN
    issue(2'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 3, 1'b0);
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32, 1'b0);
    issue(2'd3, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 2, 1'b0);
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 4, 1'b0);
`endif
    drain();

    // Hold-off then back-to-back accept while the stalled response drains
    rdy_mode = 2;
    issue_m(2'd0, 32'h1234_5678, 32'h0000_0305, 1'b1);
    w = 0;
    while (!out_val && w < 100) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    rdy_mode = 1;
    issue(2'd0, 32'd9, 32'd11, 1'b0, 32'd99, ref_lat(2'd0, 32'd9, 32'd11), 1'b1);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom & $urandom & $urandom;
        2:       rb = 32'd1 << $urandom_range(0, 31);
        default: rb = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'd0;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      issue_m(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset between edges in the middle of a calculation
    rdy_mode = 1;
    issue_m(2'd0, 32'd7, 32'h8000_0000, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midcalc_reset_out_val", {63'b0, out_val}, 64'd0);
    chk("midcalc_reset_in_rdy", {63'b0, in_rdy}, 64'd0);
    chk("midcalc_reset_out_msg", {32'b0, out_msg}, 64'd0);
    chk("midcalc_reset_out_domain", {63'b0, out_domain}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_midcalc_release", {63'b0, in_rdy}, 64'd1);
    repeat (10) @(negedge clk);
    issue_m(2'd0, 32'd6, 32'd7, 1'b0);
    issue_m(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
